// File: rtl/mdio_arb_pkg.sv
// Shared FSM encoding and constants for the MDIO register-access arbiter.
package mdio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic [15:0] ERR_DATA          = 16'hFFFF;
    localparam logic [23:0] DEF_TIMEOUT_CYC   = 24'd50_000;
    localparam logic [15:0] DEF_LOCK_IDLE_CYC = 16'd1_000;

endpackage

// File: rtl/mdio_rr_pick.sv
// Rotating-priority encoder: first request at or after rr_ptr wins, or only
// the lock owner when a lock is held.
module mdio_rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    input  logic             lock_valid_i,
    input  logic [IDX_W-1:0] lock_owner_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic [IDX_W-1:0] idx;

    // Scanning from the farthest offset down lets the nearest candidate overwrite the rest.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = '0;
        if (lock_valid_i) begin
            grant_valid_o = req_i[lock_owner_i];
            grant_idx_o   = lock_owner_i;
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                idx = IDX_W'((int'(rr_ptr_i) + i) % N_REQ);
                if (req_i[idx]) begin
                    grant_valid_o = 1'b1;
                    grant_idx_o   = idx;
                end
            end
        end
    end

endmodule

// File: rtl/mdio_arb.sv
// Round-robin arbiter sharing one MDIO driver between N_REQ requesters, with
// optional grant lock for read-modify-write and a watchdog on the driver.
module mdio_arb
    import mdio_arb_pkg::*;
#(
    parameter int          N_REQ         = 3,
    parameter logic [23:0] TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
    parameter logic [15:0] LOCK_IDLE_CYC = DEF_LOCK_IDLE_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_rh_wl,
    input  logic [5*N_REQ-1:0]  req_addr,
    input  logic [16*N_REQ-1:0] req_wr_data,
    input  logic [N_REQ-1:0]    req_lock,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic                rsp_err,
    output logic [15:0]         rsp_data,
    output logic                op_exec,
    output logic                op_rh_wl,
    output logic [4:0]          op_addr,
    output logic [15:0]         op_wr_data,
    input  logic                op_done,
    input  logic                op_rd_ack,
    input  logic [15:0]         op_rd_data,
    output logic                busy,
    output logic [7:0]          timeout_cnt
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, gidx_q, lock_owner_q, grant_idx;
    logic [IDX_W-1:0] gidx_next, owner_next;
    logic             lock_valid_q, grant_valid, grant_fire, wd_expired;
    logic             rh_wl_q, lock_q, err_q;
    logic [4:0]       addr_q;
    logic [15:0]      wr_data_q, data_q, idle_q;
    logic [23:0]      wd_q;
    logic [7:0]       tmo_cnt_q;

    mdio_rr_pick #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_pick (
        .req_i        (req_valid),
        .rr_ptr_i     (rr_ptr_q),
        .lock_valid_i (lock_valid_q),
        .lock_owner_i (lock_owner_q),
        .grant_valid_o(grant_valid),
        .grant_idx_o  (grant_idx)
    );

    // Gating with rst keeps req_ready low while reset is held.
    assign grant_fire = (state_q == ST_IDLE) && grant_valid && !rst;
    assign wd_expired = (wd_q == TIMEOUT_CYC - 24'd1);
    assign gidx_next  = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
    assign owner_next = (lock_owner_q == IDX_W'(N_REQ - 1)) ? '0 : lock_owner_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_fire) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (op_done || wd_expired) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        op_exec   = (state_q == ST_ISSUE);
        busy      = (state_q != ST_IDLE);
        if (grant_fire) req_ready[grant_idx] = 1'b1;
        if (state_q == ST_RESP) begin
            rsp_valid[gidx_q] = 1'b1;
            rsp_err           = err_q;
            rsp_data          = data_q;
        end
    end

    assign op_rh_wl    = rh_wl_q;
    assign op_addr     = addr_q;
    assign op_wr_data  = wr_data_q;
    assign timeout_cnt = tmo_cnt_q;

    // The watchdog rests at zero in IDLE, so it reads 0 in the op_exec cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gidx_q    <= '0;
            rh_wl_q   <= 1'b1;
            addr_q    <= '0;
            wr_data_q <= '0;
            lock_q    <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
            wd_q      <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (grant_fire) begin
                gidx_q    <= grant_idx;
                rh_wl_q   <= req_rh_wl[grant_idx];
                addr_q    <= req_addr[5*grant_idx +: 5];
                wr_data_q <= req_wr_data[16*grant_idx +: 16];
                lock_q    <= req_lock[grant_idx];
            end
            wd_q <= (state_q == ST_IDLE) ? '0 : wd_q + 24'd1;
            if (state_q == ST_WAIT) begin
                if (op_done) begin
                    err_q  <= rh_wl_q & op_rd_ack;
                    data_q <= !rh_wl_q ? 16'h0000 : (op_rd_ack ? ERR_DATA : op_rd_data);
                end else if (wd_expired) begin
                    err_q  <= 1'b1;
                    data_q <= ERR_DATA;
                    if (tmo_cnt_q != 8'hFF) tmo_cnt_q <= tmo_cnt_q + 8'd1;
                end
            end
        end
    end

    // Lock ownership, rotation pointer and the idle-lock release counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= '0;
            idle_q       <= '0;
        end else if (state_q == ST_RESP) begin
            idle_q <= '0;
            if (lock_q) begin
                lock_valid_q <= 1'b1;
                lock_owner_q <= gidx_q;
            end else begin
                lock_valid_q <= 1'b0;
                rr_ptr_q     <= gidx_next;
            end
        end else if (state_q == ST_IDLE && lock_valid_q && !req_valid[lock_owner_q]) begin
            if (idle_q == LOCK_IDLE_CYC - 16'd1) begin
                lock_valid_q <= 1'b0;
                rr_ptr_q     <= owner_next;
                idle_q       <= '0;
            end else begin
                idle_q <= idle_q + 16'd1;
            end
        end else begin
            idle_q <= '0;
        end
    end

endmodule

// File: tb/tb_mdio_arb.sv
// Directed bench for mdio_arb: bench-side MDIO driver model, event logs, and
// per-scenario tasks comparing the logs against hand-derived cycle counts.
module tb_mdio_arb;

    localparam int N = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_rh_wl = '0;
    logic [5*N-1:0]    req_addr = '0;
    logic [16*N-1:0]   req_wr_data = '0;
    logic [N-1:0]      req_lock = '0;
    logic [N-1:0]      req_ready, rsp_valid;
    logic              rsp_err, op_exec, op_rh_wl, op_done, busy;
    logic [15:0]       rsp_data, op_wr_data;
    logic [4:0]        op_addr;
    logic              op_rd_ack = 1'b0;
    logic [15:0]       op_rd_data = '0;
    logic [7:0]        timeout_cnt;

    int                vecs = 0;
    int                errs = 0;
    int                cyc = 0;
    int                reqIssued[N];
    int                reqAccepted[N];
    bit                drvEn = 1'b1;
    int                drvDelay = 0;
    logic              drvAckV = 1'b0;
    logic [15:0]       drvDataV = '0;
    logic              drvDone = 1'b0;
    logic              strayDone = 1'b0;

    int                gIdx[$], gCyc[$], eCyc[$], rIdx[$], rCyc[$];
    logic [4:0]        eAddr[$];
    logic              eRh[$], rErr[$];
    logic [15:0]       eWd[$], rData[$];

    assign op_done = drvDone | strayDone;

    mdio_arb #(
        .N_REQ(N),
        .TIMEOUT_CYC(24'd100),
        .LOCK_IDLE_CYC(16'd20)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rh_wl(req_rh_wl), .req_addr(req_addr),
        .req_wr_data(req_wr_data), .req_lock(req_lock), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .op_exec(op_exec), .op_rh_wl(op_rh_wl), .op_addr(op_addr),
        .op_wr_data(op_wr_data), .op_done(op_done), .op_rd_ack(op_rd_ack),
        .op_rd_data(op_rd_data), .busy(busy), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < N; i++) begin
            reqIssued[i]   = 0;
            reqAccepted[i] = 0;
        end
    end

    // A requester holds req_valid while it has issued more requests than were accepted.
    always begin
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) req_valid[i] = (reqIssued[i] > reqAccepted[i]);
    end

    // Event logger, sampled mid-cycle; cleared while reset is held.
    always @(negedge clk) begin
        if (rst) begin
            gIdx.delete(); gCyc.delete(); eCyc.delete(); eAddr.delete(); eRh.delete();
            eWd.delete(); rIdx.delete(); rCyc.delete(); rErr.delete(); rData.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] === 1'b1) begin
                    gIdx.push_back(i);
                    gCyc.push_back(cyc);
                    reqAccepted[i] <= reqAccepted[i] + 1;
                end
                if (rsp_valid[i] === 1'b1) begin
                    rIdx.push_back(i);
                    rCyc.push_back(cyc);
                    rErr.push_back(rsp_err);
                    rData.push_back(rsp_data);
                end
            end
            if (op_exec === 1'b1) begin
                eCyc.push_back(cyc);
                eAddr.push_back(op_addr);
                eRh.push_back(op_rh_wl);
                eWd.push_back(op_wr_data);
            end
        end
    end

    // MDIO driver model: op_done arrives drvDelay+1 cycles after op_exec.
    always begin
        @(negedge clk);
        if (!rst && op_exec === 1'b1 && drvEn) begin
            repeat (drvDelay) @(posedge clk);
            @(posedge clk);
            #1;
            drvDone    = 1'b1;
            op_rd_ack  = drvAckV;
            op_rd_data = drvDataV;
            @(posedge clk);
            #1;
            drvDone    = 1'b0;
            op_rd_ack  = 1'b0;
            op_rd_data = '0;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "[TB] time limit");
    end

    task automatic issueReq(input int i, input logic rh, input logic [4:0] a,
                            input logic [15:0] wd, input logic lk, input int n);
        req_rh_wl[i]           = rh;
        req_addr[5*i +: 5]     = a;
        req_wr_data[16*i +: 16] = wd;
        req_lock[i]            = lk;
        reqIssued[i]           = reqIssued[i] + n;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drvEn = 1'b1; drvDelay = 0; drvAckV = 1'b0; drvDataV = '0; strayDone = 1'b0;
        for (int i = 0; i < N; i++) reqIssued[i] = reqAccepted[i];
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic waitRsp(input int n, input int budget, output bit ok);
        int k = 0;
        while (rIdx.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        ok = (rIdx.size() >= n);
    endtask

    task automatic waitGrant(input int n, input int budget, output bit ok);
        int k = 0;
        while (gIdx.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        ok = (gIdx.size() >= n);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        vecs++; if (op_exec !== 1'b0) begin errs++; $display("[TB] FAIL rst_op_exec: got %b expected 0", op_exec); end
        vecs++; if (op_rh_wl !== 1'b1) begin errs++; $display("[TB] FAIL rst_op_rh_wl: got %b expected 1", op_rh_wl); end
        vecs++; if ({req_ready, rsp_valid, rsp_err} !== '0) begin errs++; $display("[TB] FAIL rst_handshakes: got %b expected 0", {req_ready, rsp_valid, rsp_err}); end
        vecs++; if ({op_addr, op_wr_data, rsp_data, timeout_cnt} !== '0) begin errs++; $display("[TB] FAIL rst_data_outs: got %h expected 0", {op_addr, op_wr_data, rsp_data, timeout_cnt}); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        vecs++; if (busy !== 1'b0 || op_rh_wl !== 1'b1) begin errs++; $display("[TB] FAIL post_rst_idle: got busy=%b rh_wl=%b expected 0/1", busy, op_rh_wl); end
    endtask

    task automatic test_single_read();
        bit ok;
        doReset();
        @(posedge clk);
        #1;
        drvDelay = 2; drvAckV = 1'b0; drvDataV = 16'h796D;
        issueReq(0, 1'b1, 5'd1, 16'h0000, 1'b0, 1);
        waitRsp(1, 40, ok);
        vecs++; if (!ok) begin errs++; $display("[TB] FAIL single_rsp_seen: got %0d responses expected 1", rIdx.size()); end
        repeat (4) @(negedge clk);
        vecs++; if (gIdx.size() != 1 || gIdx[0] != 0) begin errs++; $display("[TB] FAIL single_grant: got %0d grants, first %0d expected one to 0", gIdx.size(), gIdx[0]); end
        vecs++; if (eCyc.size() != 1) begin errs++; $display("[TB] FAIL single_exec_count: got %0d expected 1", eCyc.size()); end
        vecs++; if (eCyc[0] - gCyc[0] != 1) begin errs++; $display("[TB] FAIL single_exec_latency: got %0d expected 1", eCyc[0] - gCyc[0]); end
        vecs++; if (eAddr[0] !== 5'd1 || eRh[0] !== 1'b1) begin errs++; $display("[TB] FAIL single_op_fields: got addr=%0d rh=%b expected 1/1", eAddr[0], eRh[0]); end
        vecs++; if (rIdx[0] != 0) begin errs++; $display("[TB] FAIL single_rsp_idx: got %0d expected 0", rIdx[0]); end
        vecs++; if (rData[0] !== 16'h796D || rErr[0] !== 1'b0) begin errs++; $display("[TB] FAIL single_rsp: got data=%h err=%b expected 796d/0", rData[0], rErr[0]); end
        vecs++; if (rCyc[0] - eCyc[0] != 4) begin errs++; $display("[TB] FAIL single_rsp_latency: got %0d expected 4", rCyc[0] - eCyc[0]); end
    endtask

    task automatic test_fairness();
        bit ok;
        int expOrder[6] = '{0, 1, 2, 0, 1, 2};
        int perReq[N];
        doReset();
        @(posedge clk);
        #1;
        drvDelay = 1; drvAckV = 1'b0;
        for (int i = 0; i < N; i++) issueReq(i, 1'b0, 5'(10 + i), 16'h1000 + 16'(i), 1'b0, 2);
        waitRsp(6, 150, ok);
        vecs++; if (!ok) begin errs++; $display("[TB] FAIL fair_rsp_seen: got %0d responses expected 6", rIdx.size()); end
        for (int i = 0; i < N; i++) perReq[i] = 0;
        for (int k = 0; k < 6; k++) begin
            if (rIdx[k] >= 0 && rIdx[k] < N) perReq[rIdx[k]]++;
            vecs++; if (gIdx[k] != expOrder[k]) begin errs++; $display("[TB] FAIL fair_grant_%0d: got %0d expected %0d", k, gIdx[k], expOrder[k]); end
            vecs++; if (eWd[k] !== 16'h1000 + 16'(expOrder[k])) begin errs++; $display("[TB] FAIL fair_wdata_%0d: got %h expected %h", k, eWd[k], 16'h1000 + 16'(expOrder[k])); end
        end
        for (int k = 0; k < 5; k++) begin
            vecs++; if (eCyc[k+1] - rCyc[k] != 2) begin errs++; $display("[TB] FAIL fair_gap_%0d: got %0d expected 2", k, eCyc[k+1] - rCyc[k]); end
        end
        for (int i = 0; i < N; i++) begin
            vecs++; if (perReq[i] != 2) begin errs++; $display("[TB] FAIL fair_rsp_count_%0d: got %0d expected 2", i, perReq[i]); end
        end
    endtask

    task automatic test_lock_rmw();
        bit ok;
        int expOrder[4] = '{0, 0, 1, 0};
        doReset();
        @(posedge clk);
        #1;
        drvDelay = 1; drvAckV = 1'b0; drvDataV = 16'h1234;
        issueReq(0, 1'b1, 5'd27, 16'h0000, 1'b1, 1);
        issueReq(1, 1'b1, 5'd3, 16'h0000, 1'b0, 1);
        waitRsp(1, 40, ok);
        @(posedge clk);
        #1;
        issueReq(0, 1'b0, 5'd27, 16'h848B, 1'b0, 1);
        waitRsp(2, 40, ok);
        @(posedge clk);
        #1;
        issueReq(0, 1'b1, 5'd2, 16'h0000, 1'b0, 1);
        waitRsp(4, 80, ok);
        vecs++; if (!ok) begin errs++; $display("[TB] FAIL lock_rsp_seen: got %0d responses expected 4", rIdx.size()); end
        for (int k = 0; k < 4; k++) begin
            vecs++; if (gIdx[k] != expOrder[k]) begin errs++; $display("[TB] FAIL lock_grant_%0d: got %0d expected %0d", k, gIdx[k], expOrder[k]); end
        end
        vecs++; if (eAddr[0] !== 5'd27 || rData[0] !== 16'h1234) begin errs++; $display("[TB] FAIL lock_read: got addr=%0d data=%h expected 27/1234", eAddr[0], rData[0]); end
        vecs++; if (eRh[1] !== 1'b0 || eWd[1] !== 16'h848B || eAddr[1] !== 5'd27) begin errs++; $display("[TB] FAIL lock_write: got rh=%b wd=%h addr=%0d expected 0/848b/27", eRh[1], eWd[1], eAddr[1]); end
        vecs++; if (rData[1] !== 16'h0000 || rErr[1] !== 1'b0) begin errs++; $display("[TB] FAIL lock_write_rsp: got data=%h err=%b expected 0/0", rData[1], rErr[1]); end
        vecs++; if (eAddr[2] !== 5'd3) begin errs++; $display("[TB] FAIL lock_third_addr: got %0d expected 3", eAddr[2]); end
    endtask

    task automatic test_nack();
        bit ok;
        doReset();
        @(posedge clk);
        #1;
        drvDelay = 0; drvAckV = 1'b1; drvDataV = 16'h5555;
        issueReq(2, 1'b1, 5'd4, 16'h0000, 1'b0, 1);
        waitRsp(1, 40, ok);
        @(posedge clk);
        #1;
        issueReq(2, 1'b0, 5'd4, 16'hABCD, 1'b0, 1);
        waitRsp(2, 40, ok);
        vecs++; if (!ok) begin errs++; $display("[TB] FAIL nack_rsp_seen: got %0d responses expected 2", rIdx.size()); end
        vecs++; if (rIdx[0] != 2 || rIdx[1] != 2) begin errs++; $display("[TB] FAIL nack_rsp_idx: got %0d,%0d expected 2,2", rIdx[0], rIdx[1]); end
        vecs++; if (rErr[0] !== 1'b1 || rData[0] !== 16'hFFFF) begin errs++; $display("[TB] FAIL nack_read: got err=%b data=%h expected 1/ffff", rErr[0], rData[0]); end
        vecs++; if (rErr[1] !== 1'b0 || rData[1] !== 16'h0000) begin errs++; $display("[TB] FAIL nack_write: got err=%b data=%h expected 0/0000", rErr[1], rData[1]); end
        vecs++; if (eWd[1] !== 16'hABCD) begin errs++; $display("[TB] FAIL nack_write_data: got %h expected abcd", eWd[1]); end
    endtask

    task automatic test_timeout();
        bit ok;
        doReset();
        @(posedge clk);
        #1;
        drvEn = 1'b0;
        issueReq(1, 1'b1, 5'd9, 16'h0000, 1'b0, 1);
        waitRsp(1, 150, ok);
        vecs++; if (!ok) begin errs++; $display("[TB] FAIL tmo_rsp_seen: got %0d responses expected 1", rIdx.size()); end
        vecs++; if (rCyc[0] - eCyc[0] != 100) begin errs++; $display("[TB] FAIL tmo_latency: got %0d expected 100", rCyc[0] - eCyc[0]); end
        vecs++; if (rIdx[0] != 1 || rErr[0] !== 1'b1 || rData[0] !== 16'hFFFF) begin errs++; $display("[TB] FAIL tmo_rsp: got idx=%0d err=%b data=%h expected 1/1/ffff", rIdx[0], rErr[0], rData[0]); end
        vecs++; if (timeout_cnt !== 8'd1) begin errs++; $display("[TB] FAIL tmo_count: got %0d expected 1", timeout_cnt); end
        repeat (10) @(posedge clk);
        #1 strayDone = 1'b1;
        @(posedge clk);
        #1 strayDone = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        vecs++; if (rIdx.size() != 1) begin errs++; $display("[TB] FAIL tmo_stray_done: got %0d responses expected 1", rIdx.size()); end
        vecs++; if (busy !== 1'b0 || timeout_cnt !== 8'd1) begin errs++; $display("[TB] FAIL tmo_after_stray: got busy=%b cnt=%0d expected 0/1", busy, timeout_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        doReset();
        @(posedge clk);
        #1;
        drvEn = 1'b0;
        issueReq(0, 1'b1, 5'd7, 16'h0000, 1'b0, 1);
        waitRsp(0, 0, ok);
        for (int k = 0; k < 20 && eCyc.size() == 0; k++) begin
            @(negedge clk);
            #1;
        end
        repeat (3) @(negedge clk);
        #1;
        vecs++; if (busy !== 1'b1) begin errs++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        vecs++; if (busy !== 1'b0 || op_exec !== 1'b0 || op_rh_wl !== 1'b1) begin errs++; $display("[TB] FAIL midrst_ctrl: got busy=%b exec=%b rh=%b expected 0/0/1", busy, op_exec, op_rh_wl); end
        vecs++; if ({op_addr, rsp_valid, req_ready, rsp_data} !== '0) begin errs++; $display("[TB] FAIL midrst_outs: got %h expected 0", {op_addr, rsp_valid, req_ready, rsp_data}); end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) reqIssued[i] = reqAccepted[i];
        @(posedge clk);
        #1;
        rst = 1'b0;
        drvEn = 1'b1; drvDelay = 0; drvAckV = 1'b0; drvDataV = 16'hC0DE;
        @(posedge clk);
        #1;
        issueReq(2, 1'b1, 5'd12, 16'h0000, 1'b0, 1);
        waitRsp(1, 40, ok);
        repeat (3) @(negedge clk);
        vecs++; if (!ok || rIdx.size() != 1 || rIdx[0] != 2) begin errs++; $display("[TB] FAIL midrst_new_rsp: got %0d responses, first idx %0d expected one to 2", rIdx.size(), rIdx[0]); end
        vecs++; if (gIdx[0] != 2 || eAddr[0] !== 5'd12) begin errs++; $display("[TB] FAIL midrst_new_grant: got idx=%0d addr=%0d expected 2/12", gIdx[0], eAddr[0]); end
        vecs++; if (rData[0] !== 16'hC0DE || rErr[0] !== 1'b0) begin errs++; $display("[TB] FAIL midrst_new_data: got data=%h err=%b expected c0de/0", rData[0], rErr[0]); end
    endtask

    task automatic test_lock_idle();
        bit ok;
        int r0;
        doReset();
        @(posedge clk);
        #1;
        drvDelay = 0; drvAckV = 1'b0; drvDataV = 16'h0042;
        issueReq(0, 1'b1, 5'd5, 16'h0000, 1'b1, 1);
        waitRsp(1, 40, ok);
        r0 = rCyc[0];
        @(posedge clk);
        #1;
        issueReq(1, 1'b1, 5'd6, 16'h0000, 1'b0, 1);
        waitGrant(2, 60, ok);
        vecs++; if (!ok) begin errs++; $display("[TB] FAIL lockidle_grant_seen: got %0d grants expected 2", gIdx.size()); end
        vecs++; if (gIdx[1] != 1) begin errs++; $display("[TB] FAIL lockidle_grant_idx: got %0d expected 1", gIdx[1]); end
        vecs++; if (gCyc[1] - r0 != 21) begin errs++; $display("[TB] FAIL lockidle_release_delay: got %0d expected 21", gCyc[1] - r0); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_lock_rmw();
        test_nack();
        test_timeout();
        test_reset_mid_wait();
        test_lock_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mdio_arb.md
Name: mdio_arb

Overview:
Round-robin arbiter sharing the single MDIO register-access driver (op_exec/op_done handshake) between N_REQ requesters: PHY config sequencer, periodic link/speed monitor, and the debug register port.
- Serialises one transaction at a time and routes each response back to its issuer.
- Optional lock keeps grant across read-modify-write sequences.
- Watchdog converts a hung driver into an error response.

Parameters:
N_REQ, 3, number of requesters (2..8); index 0 has highest priority after reset.
TIMEOUT_CYC, 24'd50_000, cycles from op_exec to forced error if op_done never arrives.
LOCK_IDLE_CYC, 16'd1_000, cycles a locked owner may leave idle before the lock is dropped.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester request, held until req_ready
req_rh_wl  in  N_REQ  1=read, 0=write
req_addr  in  5*N_REQ  register address, requester i at [5i+4:5i]
req_wr_data  in  16*N_REQ  write data, requester i at [16i+15:16i]
req_lock  in  N_REQ  keep grant after this transaction
req_ready  out  N_REQ  one-cycle accept pulse
rsp_valid  out  N_REQ  one-cycle completion pulse
rsp_err  out  1  valid with rsp_valid: read NACK or timeout
rsp_data  out  16  valid with rsp_valid
op_exec  out  1  one-cycle start to MDIO driver
op_rh_wl  out  1  to driver
op_addr  out  5  to driver
op_wr_data  out  16  to driver
op_done  in  1  driver completion pulse
op_rd_ack  in  1  driver read ack, 0 = PHY acknowledged
op_rd_data  in  16  driver read data
busy  out  1  high outside IDLE
timeout_cnt  out  8  saturating count of watchdog expiries

Behaviour:
Reset values:
- Outputs 0, except op_rh_wl=1.
- rr_ptr=0, lock_owner invalid, FSM=IDLE.
- Any in-flight transaction is abandoned with no rsp_valid. The driver shares rst.

IDLE:
- If a lock is held, only the owner is eligible. Otherwise pick the first req_valid at or after rr_ptr, wrapping.
- In the same cycle, pulse req_ready[g], latch rh_wl/addr/wr_data/lock of g, and go to ISSUE.
- No request: stay in IDLE.

ISSUE:
- op_exec=1 for exactly one cycle; op_rh_wl/op_addr/op_wr_data driven from latches and held stable until the next ISSUE.
- Clear the watchdog; go to WAIT.

WAIT:
- op_done=1: capture result and go to RESP.
  - Read with op_rd_ack=0: err=0, data=op_rd_data.
  - Read with op_rd_ack=1: err=1, data=16'hFFFF.
  - Write: err=0, data=0; op_rd_ack is ignored.
- Watchdog reaches TIMEOUT_CYC-1 without op_done: err=1, data=16'hFFFF, timeout_cnt+1 (saturating at 255), go to RESP.
- op_done together with the final watchdog cycle: op_done wins.

RESP:
- rsp_valid[g]=1 for one cycle with rsp_err/rsp_data; go to IDLE.
- Latched lock=1: lock_owner=g, rr_ptr unchanged.
- Latched lock=0: lock released, rr_ptr=(g+1) mod N_REQ.

Stray events:
- op_done outside WAIT is ignored and produces no response. A late op_done after a timeout is therefore dropped.

Latency:
- Accept at cycle T, op_exec at T+1.
- op_done at D gives rsp_valid at D+1.
- Minimum gap between successive op_exec pulses is 3 cycles after op_done.

Lock idle:
- While a lock is held and the owner's req_valid=0, count idle cycles.
- At LOCK_IDLE_CYC-1, release the lock and advance rr_ptr past the owner.

Misc:
- Requests that are not granted remain pending.
- A requester may present a new request in the cycle its rsp_valid is high; it is evaluated in the next IDLE cycle.

Decomposition:
Package mdio_arb_pkg:
- FSM state encodings (IDLE, ISSUE, WAIT, RESP).
- Constant ERR_DATA=16'hFFFF.
- Default timeout constants.

Sub-module mdio_rr_pick:
- Combinational rotate-priority encoder.
- Inputs: req vector, rr_ptr, lock_valid, lock_owner.
- Outputs: grant_valid, grant_idx.

Test Plan:
1. Single read: req 0 read addr 5'd1; driver answers op_done with rd_ack=0, data 16'h796D -> op_exec once at T+1 with op_addr=1, rsp_valid[0] with rsp_data=16'h796D, rsp_err=0.
2. Fairness: req 0,1,2 all held valid for 6 transactions -> grant order 0,1,2,0,1,2; no op_exec overlap; each requester sees exactly 2 rsp_valid pulses.
3. Lock RMW: req 0 read addr 27 with lock=1 while req 1 valid; req 0 writes 16'h848B with lock=0 -> both req 0 transactions complete before req 1's req_ready; then rr_ptr=1.
4. Read NACK: op_done with op_rd_ack=1 -> rsp_err=1, rsp_data=16'hFFFF; write with rd_ack=1 -> rsp_err=0.
5. Timeout: TIMEOUT_CYC=100, driver silent -> rsp_err=1 exactly 100 cycles after op_exec, timeout_cnt=1; a stray op_done 10 cycles later produces no rsp_valid.
6. Reset mid-WAIT: assert rst while busy -> all outputs 0 and op_rh_wl=1 immediately; after release, a new request from req 2 is granted normally.
